// File: rtl/regfile_port_arbiter_pkg.sv
// Shared encodings for regfile_port_arbiter: register-file modes, arbiter FSM states and owner ids.
// WORD mirrors the core-wide data word width; REG_MODE_IDLE is distinct from IN/OUT.
package regfile_port_arbiter_pkg;

  localparam int WORD          = 16;
  localparam int RF_ADDR_W     = 6;
  localparam int RF_PROT_LIMIT = 4;

  typedef enum logic [1:0] {
    REG_MODE_IDLE = 2'b00,
    REG_MODE_IN   = 2'b01,
    REG_MODE_OUT  = 2'b10
  } reg_mode_e;

  typedef enum logic [1:0] {
    RARB_IDLE       = 2'b00,
    RARB_WRITE      = 2'b01,
    RARB_RD_ISSUE   = 2'b10,
    RARB_RD_CAPTURE = 2'b11
  } rarb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  function automatic logic sel_below(input logic [31:0] sel, input logic [31:0] limit);
    return sel < limit;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant, pointer register that flips away from
// the granted requester only when the caller asserts advance.
module rr_arb2
  import regfile_port_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   clear_n,
  input  logic   req_a,
  input  logic   req_b,
  input  logic   advance,
  output logic   gnt_valid,
  output owner_e gnt
);

  owner_e ptr_q, ptr_d;

  // Grant selection and pointer update.
  always_comb begin
    gnt_valid = req_a | req_b;
    if (req_a && req_b) begin
      gnt = ptr_q;
    end else if (req_b) begin
      gnt = OWNER_B;
    end else begin
      gnt = OWNER_A;
    end
    if (advance && gnt_valid) begin
      ptr_d = (gnt == OWNER_A) ? OWNER_B : OWNER_A;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ptr_q <= OWNER_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single-port 64x16 register file between requesters A and B with round-robin fairness.
// Define REGARB_CONST_PROTECT_EN to make registers below PROT_LIMIT write-protected (ack with err).
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int WIDTH      = WORD,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int PROT_LIMIT = RF_PROT_LIMIT
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_sel,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_ack,
  output logic [WIDTH-1:0]  a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_sel,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_ack,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] rf_sel,
  output logic [1:0]        rf_mode,
  output logic [WIDTH-1:0]  rf_wdata,
  input  logic [WIDTH-1:0]  rf_rdata
);

  rarb_state_e       state_q, state_d;
  owner_e            owner_q, owner_d;
  reg_mode_e         rf_mode_q, rf_mode_d;
  logic [ADDR_W-1:0] rf_sel_q, rf_sel_d;
  logic [WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;

  logic              gnt_valid, advance, g_we, prot;
  owner_e            gnt;
  logic [ADDR_W-1:0] g_sel;
  logic [WIDTH-1:0]  g_wdata;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .clear_n   (clear_n),
    .req_a     (a_req),
    .req_b     (b_req),
    .advance   (advance),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // Request fields of whichever requester the picker favours this cycle.
  always_comb begin
    if (gnt == OWNER_B) begin
      g_we    = b_we;
      g_sel   = b_sel;
      g_wdata = b_wdata;
    end else begin
      g_we    = a_we;
      g_sel   = a_sel;
      g_wdata = a_wdata;
    end
  end

`ifdef REGARB_CONST_PROTECT_EN
  assign prot = g_we & sel_below(32'(g_sel), 32'(PROT_LIMIT));
`else
  assign prot = 1'b0;
`endif

  // Next-state, grant and register-file command logic; the pointer moves only on contested grants.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rf_sel_d   = rf_sel_q;
    rf_wdata_d = rf_wdata_q;
    rf_mode_d  = REG_MODE_IDLE;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    advance    = 1'b0;
    case (state_q)
      RARB_IDLE: begin
        if (gnt_valid) begin
          advance    = a_req & b_req;
          owner_d    = gnt;
          rf_sel_d   = g_sel;
          rf_wdata_d = g_wdata;
          if (g_we) begin
            state_d   = RARB_WRITE;
            rf_mode_d = prot ? REG_MODE_IDLE : REG_MODE_IN;
            a_ack_d   = (gnt == OWNER_A);
            b_ack_d   = (gnt == OWNER_B);
            a_err_d   = prot & (gnt == OWNER_A);
            b_err_d   = prot & (gnt == OWNER_B);
          end else begin
            state_d   = RARB_RD_ISSUE;
            rf_mode_d = REG_MODE_OUT;
          end
        end else begin
          state_d = RARB_IDLE;
        end
      end
      RARB_WRITE: begin
        state_d = RARB_IDLE;
      end
      RARB_RD_ISSUE: begin
        state_d = RARB_RD_CAPTURE;
        a_ack_d = (owner_q == OWNER_A);
        b_ack_d = (owner_q == OWNER_B);
      end
      RARB_RD_CAPTURE: begin
        state_d = RARB_IDLE;
      end
      default: begin
        state_d = RARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= RARB_IDLE;
      owner_q    <= OWNER_A;
      rf_mode_q  <= REG_MODE_IDLE;
      rf_sel_q   <= {ADDR_W{1'b0}};
      rf_wdata_q <= {WIDTH{1'b0}};
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rf_mode_q  <= rf_mode_d;
      rf_sel_q   <= rf_sel_d;
      rf_wdata_q <= rf_wdata_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
    end
  end

  assign rf_sel   = rf_sel_q;
  assign rf_mode  = rf_mode_q;
  assign rf_wdata = rf_wdata_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  // Read data is the register file's own registered output, forwarded only to the capturing owner.
  assign a_rdata  = (state_q == RARB_RD_CAPTURE && owner_q == OWNER_A) ? rf_rdata : {WIDTH{1'b0}};
  assign b_rdata  = (state_q == RARB_RD_CAPTURE && owner_q == OWNER_B) ? rf_rdata : {WIDTH{1'b0}};

endmodule
